// File: rtl/psec_pkg.sv
// psec_pkg: shared state/mode types and group-size helper for the trigger sequencer
package psec_pkg;
    typedef enum logic [2:0] {INIT, STOPPED, SAMPLING, SLOW, READOUT} state_t;
    typedef enum logic [1:0] {SAMPLE1, SAMPLE2, SAMPLE4, SAMPLEALL} smode_t;
    function automatic int unsigned mode_to_group_size(input smode_t m, input int unsigned nb);
        int unsigned g;
        g = (m == SAMPLEALL) ? nb : (32'd1 << m);
        return (g > nb) ? nb : g;
    endfunction
endpackage

// File: rtl/psec_disc_sync.sv
// psec_disc_sync: discriminator synchroniser with registered rising-edge pulse
module psec_disc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sr;
    logic prev;
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr <= '0;
            prev <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], din};
            prev <= sr[SYNC_STAGES-1];
            pulse <= sr[SYNC_STAGES-1] & ~prev;
        end
    end
endmodule

// File: rtl/psec_trigger_sequencer.sv
// psec_trigger_sequencer: steps SCA bank groups on accepted discriminator edges, then the slow bank
module psec_trigger_sequencer
    import psec_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int CNT_W = 10,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W = 4,
    parameter int HIT_W = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           INST_START,
    input  logic                           INST_STOP,
    input  logic                           INST_READOUT,
    input  logic                           DISCRIMINATOR_OUTPUT,
    input  logic [1:0]                     MODE,
    input  logic [HOLDOFF_W-1:0]           HOLDOFF,
    input  logic [(NUM_BANKS+1)*CNT_W-1:0] CNT,
    output logic [NUM_BANKS:0]             TRIGGER,
    output logic [NUM_BANKS-1:0]           TRIGGERC,
    output logic [(NUM_BANKS+1)*CNT_W-1:0] CTMP,
    output logic [HIT_W-1:0]               HIT_COUNT,
    output logic                           BUSY,
    output logic [2:0]                     STATE
);
    localparam int LB = $clog2(NUM_BANKS);
    localparam int GW = LB + 1;
    state_t st, st_n;
    logic [LB-1:0] grp, grp_n;
    logic [GW-1:0] gsz, gsz_n;
    logic [HOLDOFF_W-1:0] hold, hold_n;
    logic [HIT_W-1:0] hit_n;
    logic [(NUM_BANKS+1)*CNT_W-1:0] ctmp_n;
    logic [NUM_BANKS:0] trig_n;
    logic [NUM_BANKS-1:0] trc_n;
    logic disc_p, acc;
    int lo, hi, lo_n, hi_n;
    psec_disc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK(CLK),
        .RST(RST),
        .din(DISCRIMINATOR_OUTPUT),
        .pulse(disc_p)
    );
    assign STATE = st;
    always_comb begin
        lo = int'(grp) * int'(gsz);
        hi = lo + int'(gsz);
        acc = disc_p && st == SAMPLING && hold == '0;
        st_n = st;
        grp_n = grp;
        gsz_n = gsz;
        ctmp_n = CTMP;
        hit_n = HIT_COUNT;
        hold_n = (hold == '0) ? hold : hold - HOLDOFF_W'(1);
        if (INST_START) begin
            st_n = SAMPLING;
            grp_n = '0;
            gsz_n = GW'(mode_to_group_size(smode_t'(MODE), $unsigned(NUM_BANKS)));
            hit_n = '0;
            hold_n = '0;
        end else if (INST_STOP) begin
            st_n = STOPPED;
            ctmp_n = CNT;
        end else if (INST_READOUT) begin
            st_n = READOUT;
        end else if (acc) begin
            hit_n = (&HIT_COUNT) ? HIT_COUNT : HIT_COUNT + HIT_W'(1);
            hold_n = HOLDOFF;
            st_n = (hi == NUM_BANKS) ? SLOW : SAMPLING;
            grp_n = (hi == NUM_BANKS) ? grp : grp + LB'(1);
        end
        lo_n = int'(grp_n) * int'(gsz_n);
        hi_n = lo_n + int'(gsz_n);
        for (int b = 0; b < NUM_BANKS; b++) begin
            trig_n[b] = (st_n == SAMPLING) ? !(b >= lo_n && b < hi_n) : 1'b1;
            trc_n[b] = (st_n != SAMPLING) || (b < lo_n);
        end
        trig_n[NUM_BANKS] = !(st_n == SAMPLING || st_n == SLOW);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            st <= INIT;
            grp <= '0;
            gsz <= GW'(1);
            hold <= '0;
            HIT_COUNT <= '0;
            CTMP <= '0;
            TRIGGER <= '1;
            TRIGGERC <= '1;
            BUSY <= 1'b0;
        end else begin
            st <= st_n;
            grp <= grp_n;
            gsz <= gsz_n;
            hold <= hold_n;
            HIT_COUNT <= hit_n;
            CTMP <= ctmp_n;
            TRIGGER <= trig_n;
            TRIGGERC <= trc_n;
            BUSY <= (st_n == SAMPLING || st_n == SLOW);
        end
    end
endmodule
